active_list_ctrl: RTL

// Sequencing controller for the 32-entry active list (reorder buffer) of the out-of-order MIPS core.

---
 rtl/active_list_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/active_list_ctrl.sv
// Active-list (ROB) sequencer: in-order allocate, out-of-order done marking, in-order retire,
// and youngest-first squash walk-back after a branch flush.
module active_list_ctrl #(
  parameter  int DEPTH  = 32,
  parameter  int LOG_W  = 5,
  parameter  int PHYS_W = 6,
  localparam int TAG_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_valid,
  input  logic [LOG_W-1:0]  alloc_logical,
  input  logic [PHYS_W-1:0] alloc_phys_new,
  input  logic [PHYS_W-1:0] alloc_phys_old,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              done_valid,
  input  logic [TAG_W-1:0]  done_tag,
  input  logic              commit_ready,
  output logic              commit_valid,
  output logic [LOG_W-1:0]  commit_logical,
  output logic [PHYS_W-1:0] commit_phys_new,
  output logic [PHYS_W-1:0] commit_phys_old,
  input  logic              flush_valid,
  input  logic [TAG_W-1:0]  flush_tag,
  output logic              squash_valid,
  output logic [LOG_W-1:0]  squash_logical,
  output logic [PHYS_W-1:0] squash_phys_new,
  output logic [PHYS_W-1:0] squash_phys_old,
  output logic [CNT_W-1:0]  count
);

  typedef enum logic {RUN, WALK} state_t;

  typedef struct packed {
    logic [LOG_W-1:0]  lg;
    logic [PHYS_W-1:0] pn;
    logic [PHYS_W-1:0] po;
  } entry_t;

  localparam logic [TAG_W-1:0] TAG_ONE = TAG_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  state_t           state, state_nx;
  logic [TAG_W-1:0] head, tail, tgt;
  logic [CNT_W-1:0] cnt;
  logic [DEPTH-1:0] done;
  entry_t           ent [DEPTH];

  logic [TAG_W-1:0] done_dist, flush_dist, tgt_dist, tail_m1, flush_nxt;
  logic             done_ok, flush_ok, flush_walk;
  logic             alloc_fire, commit_fire, squash_fire;

  assign tail_m1    = tail - TAG_ONE;
  assign flush_nxt  = flush_tag + TAG_ONE;
  assign done_dist  = done_tag - head;
  assign flush_dist = flush_tag - head;
  assign tgt_dist   = tgt - head;

  // During WALK only entries older than the walk target survive; late dones on doomed entries are dropped.
  assign done_ok    = done_valid && ({1'b0, done_dist} < cnt) &&
                      (state == RUN || done_dist < tgt_dist);
  assign flush_ok   = (state == RUN) && flush_valid && ({1'b0, flush_dist} < cnt);
  // tail == flush_tag+1 means the branch is already the youngest entry (also covers the full case).
  assign flush_walk = flush_ok && (tail != flush_nxt);

  assign alloc_fire  = alloc_valid && alloc_ready;
  assign commit_fire = commit_valid && commit_ready;
  assign squash_fire = (state == WALK);

  assign alloc_tag = tail;
  assign count     = cnt;

  always_comb begin
    state_nx        = state;
    alloc_ready     = 1'b0;
    commit_valid    = 1'b0;
    squash_valid    = 1'b0;
    commit_logical  = '0;
    commit_phys_new = '0;
    commit_phys_old = '0;
    squash_logical  = '0;
    squash_phys_new = '0;
    squash_phys_old = '0;
    case (state)
      RUN: begin
        alloc_ready  = (cnt < CNT_MAX) && !flush_valid;
        commit_valid = (cnt != '0) && done[head] && !flush_valid;
        if (commit_valid) begin
          commit_logical  = ent[head].lg;
          commit_phys_new = ent[head].pn;
          commit_phys_old = ent[head].po;
        end
        if (flush_walk) state_nx = WALK;
      end
      WALK: begin
        squash_valid    = 1'b1;
        squash_logical  = ent[tail_m1].lg;
        squash_phys_new = ent[tail_m1].pn;
        squash_phys_old = ent[tail_m1].po;
        if (tail_m1 == tgt) state_nx = RUN;
      end
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      head  <= '0;
      tail  <= '0;
      tgt   <= '0;
      cnt   <= '0;
      done  <= '0;
    end else begin
      state <= state_nx;
      if (flush_walk)  tgt  <= flush_nxt;
      if (squash_fire) tail <= tail_m1;
      if (alloc_fire)  tail <= tail + TAG_ONE;
      if (commit_fire) head <= head + TAG_ONE;
      if (alloc_fire && !(commit_fire || squash_fire))      cnt <= cnt + CNT_ONE;
      else if (!alloc_fire && (commit_fire || squash_fire)) cnt <= cnt - CNT_ONE;
      // Later assignments win: retire/alloc clears override a same-cycle done on that slot.
      if (done_ok)     done[done_tag] <= 1'b1;
      if (commit_fire) done[head]     <= 1'b0;
      if (alloc_fire)  done[tail]     <= 1'b0;
    end
  end

  // Payload storage needs no reset; outputs are gated by their valids.
  always_ff @(posedge clk) begin
    if (alloc_fire) ent[tail] <= '{lg: alloc_logical, pn: alloc_phys_new, po: alloc_phys_old};
  end

endmodule
